operand_calc_ctrl: RTL and testbench
====================================

// Module: operand_calc_ctrl
// PURPOSE
//  Sequential operand-entry and arithmetic controller for the lab boards.
//  Captures two WIDTH-bit operands from switches on debounced pushbutton presses.
//  Computes add/sub in unsigned or two's-complement mode and holds a registered
//  result with flags plus a sign/magnitude form. Sits between board I/O and the
//  seven-segment decode layer, which displays operand_a, operand_b and result_mag.
// PARAMETERS
//  WIDTH            4        operand/result width in bits (>=2)
//  DEBOUNCE_CYCLES  500000   stable cycles required on key_n (10 ms @ 50 MHz)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived)
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  key_n       in   1        raw pushbutton, active-low, asynchronous to clk
//  sw_operand  in   WIDTH    operand value from switches
//  mode        in   2        [1]=0 unsigned / 1 two's complement; [0]=0 add / 1 sub
//  operand_a   out  WIDTH    captured operand A
//  operand_b   out  WIDTH    captured operand B
//  result      out  WIDTH    a op b, modulo 2^WIDTH
//  carry       out  1        unsigned add: carry-out; unsigned sub: borrow (a<b); signed: 0
//  overflow    out  1        signed: two's-complement overflow; unsigned: equals carry
//  negative    out  1        true mathematical sign of a op b (1 = negative)
//  result_mag  out  WIDTH+1  |a op b| computed exactly in WIDTH+1 bits
//  state       out  2        current FSM state encoding (for LEDs)
//  valid       out  1        1 while result/flags are valid (SHOW)
// BEHAVIOUR
//  Reset: all outputs 0, state=LOAD_A. Reset is honoured in any state, mid-debounce included.
//  Input path: key_n -> 2-flop synchroniser (reset value 1) -> debouncer.
//  Debouncer: counter clears whenever synced != stable. stable takes synced after
//   DEBOUNCE_CYCLES consecutive equal cycles. press = 1-cycle pulse on stable 1->0.
//   Glitches shorter than DEBOUNCE_CYCLES never produce press. Release makes no pulse.
//  FSM: LOAD_A=0, LOAD_B=1, COMPUTE=2, SHOW=3.
//   LOAD_A + press: operand_a<=sw_operand, valid<=0, ->LOAD_B.
//   LOAD_B + press: operand_b<=sw_operand, ->COMPUTE.
//   COMPUTE: unconditional ->SHOW after 1 cycle. mode is sampled here. Loads result,
//    carry, overflow, negative and result_mag, and sets valid<=1 on the same edge.
//   SHOW + press: ->LOAD_A. Outputs hold until the next LOAD_A press clears valid.
//   A press pulse during COMPUTE is dropped. Changes to mode or sw_operand outside
//    capture/compute edges have no effect on registered outputs.
//  Latency: press in LOAD_B at cycle n -> valid=1 and result visible at cycle n+2.
//  Arithmetic: form ext = WIDTH+1-bit extension of a and b (zero-ext unsigned,
//   sign-ext signed). full = ext_a +/- ext_b; result = full[WIDTH-1:0].
//   negative = full[WIDTH] in signed or unsigned-sub mode, 0 in unsigned-add mode.
//   result_mag = negative ? -full : full (WIDTH+1 bits, no truncation).
//   signed overflow: add -> sign(a)==sign(b)!=sign(result); sub -> sign(a)!=sign(b)
//    and sign(result)!=sign(a).
//  Edge cases:
//   key held through SHOW->LOAD_A does not re-trigger; a new 1->0 edge is required.
//   a==b subtraction gives result 0, negative 0, carry 0.
// STRUCTURE
//  Package calc_pkg: state localparams (LOAD_A..SHOW) and mode bit positions/names.
//  Sub-module key_debounce (#DEBOUNCE_CYCLES): synchroniser + counter + press pulse.
//  Top: FSM and operand registers; arithmetic is a combinational block feeding
//   result registers that are enabled in COMPUTE.
// TESTING  (WIDTH=4, DEBOUNCE_CYCLES=4)
//  1 Reset: assert rst_n=0 mid-run -> all outputs 0, state=0, valid=0, asynchronously.
//  2 Bounce: key_n low 3 cycles then high -> no state change; low 4+ cycles -> exactly one advance.
//  3 mode=00, A=1001, B=1000 -> result=0001, carry=1, ovf=1, neg=0, mag=10001, valid at press+2.
//  4 mode=01, A=0011, B=0101 -> result=1110, carry=1, neg=1, mag=00010.
//  5 mode=10, A=0111, B=0001 -> result=1000, ovf=1, neg=0, mag=01000;
//    A=1000, B=1000 -> result=0000, ovf=1, neg=1, mag=10000.
//  6 rst_n pulsed in LOAD_B -> operands cleared, state=LOAD_A; key held across SHOW->LOAD_A -> no extra capture.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared FSM state and mode-bit definitions for the operand calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    SHOW    = 2'd3
  } calc_state_t;

  // mode[MODE_SIGNED_BIT]: 0 unsigned, 1 two's complement
  // mode[MODE_SUB_BIT]   : 0 add, 1 subtract
  localparam int unsigned MODE_SIGNED_BIT = 1;
  localparam int unsigned MODE_SUB_BIT    = 0;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_TWOS     = 1'b1;
  localparam logic MODE_ADD      = 1'b0;
  localparam logic MODE_SUB      = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton synchroniser and debouncer; emits a one-cycle press
// pulse when the debounced level falls.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             synced;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      synced <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1  <= key_n;
      synced <= sync1;
      press  <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= synced;
        // stable is still 1 here only on a falling transition
        press  <= stable;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/operand_calc_ctrl.sv
// Two-operand entry FSM with registered add/sub result, flags and
// sign/magnitude output for the seven-segment layer.
module operand_calc_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_operand,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic [WIDTH:0]   result_mag,
  output logic [1:0]       state,
  output logic             valid
);

  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  calc_state_t state_q;
  logic        press;

  logic           signed_mode;
  logic           sub_op;
  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] full;
  logic           neg_c;
  logic           carry_c;
  logic           ovf_c;
  logic [WIDTH:0] mag_c;
  logic           sa;
  logic           sb;
  logic           sr;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  assign state       = state_q;
  assign signed_mode = (mode[MODE_SIGNED_BIT] == MODE_TWOS);
  assign sub_op      = (mode[MODE_SUB_BIT] == MODE_SUB);

  always_comb begin
    ext_a   = {signed_mode & operand_a[WIDTH-1], operand_a};
    ext_b   = {signed_mode & operand_b[WIDTH-1], operand_b};
    full    = sub_op ? (ext_a - ext_b) : (ext_a + ext_b);
    // Unsigned add can never be negative; bit WIDTH there is a carry, not a sign
    neg_c   = (signed_mode | sub_op) & full[WIDTH];
    mag_c   = neg_c ? ((~full) + ONE_EXT) : full;
    carry_c = ~signed_mode & full[WIDTH];
    sa      = operand_a[WIDTH-1];
    sb      = operand_b[WIDTH-1];
    sr      = full[WIDTH-1];
    if (signed_mode) begin
      ovf_c = sub_op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    end else begin
      ovf_c = carry_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      operand_a  <= '0;
      operand_b  <= '0;
      result     <= '0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      negative   <= 1'b0;
      result_mag <= '0;
      valid      <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: if (press) begin
          operand_a <= sw_operand;
          valid     <= 1'b0;
          state_q   <= LOAD_B;
        end
        LOAD_B: if (press) begin
          operand_b <= sw_operand;
          state_q   <= COMPUTE;
        end
        COMPUTE: begin
          result     <= full[WIDTH-1:0];
          carry      <= carry_c;
          overflow   <= ovf_c;
          negative   <= neg_c;
          result_mag <= mag_c;
          valid      <= 1'b1;
          state_q    <= SHOW;
        end
        SHOW: if (press) begin
          state_q <= LOAD_A;
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_calc_ctrl.sv
// Randomised scoreboard bench for operand_calc_ctrl (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_operand_calc_ctrl;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic         key_n;
  logic [W-1:0] sw_operand;
  logic [1:0]   mode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         negative;
  logic [W:0]   result_mag;
  logic [1:0]   state;
  logic         valid;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         n;
    logic [W:0]   mag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  operand_calc_ctrl #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .sw_operand(sw_operand),
    .mode      (mode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .result_mag(result_mag),
    .state     (state),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on the mathematical operand values
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m);
    int   va, vb, v;
    exp_t e;
    if (m[1]) begin
      va = (a >= 8) ? int'(a) - 16 : int'(a);
      vb = (b >= 8) ? int'(b) - 16 : int'(b);
    end else begin
      va = int'(a);
      vb = int'(b);
    end
    v     = m[0] ? va - vb : va + vb;
    e.a   = a;
    e.b   = b;
    e.res = 4'(((v % 16) + 16) % 16);
    e.n   = (v < 0);
    e.mag = 5'((v < 0) ? -v : v);
    if (m[1]) begin
      e.c = 1'b0;
      e.o = (v > 7) || (v < -8);
    end else begin
      e.c = m[0] ? (a < b) : (v > 15);
      e.o = e.c;
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever valid rises
  logic prev_valid   = 1'b0;
  logic prev_compute = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid && !prev_valid) begin
      check("latency_compute_to_valid", {31'b0, prev_compute}, 32'd1);
      if (sbq.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("operand_a", operand_a, e.a);
        check("operand_b", operand_b, e.b);
        check("result", result, e.res);
        check("carry", carry, e.c);
        check("overflow", overflow, e.o);
        check("negative", negative, e.n);
        check("result_mag", result_mag, e.mag);
      end
    end
    prev_valid   = rst_n & valid;
    prev_compute = rst_n && (state == 2'd2);
  end

  task automatic press(int low);
    @(negedge clk);
    key_n = 1'b0;
    repeat (low) @(negedge clk);
    key_n = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic run_tx(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] m, int show_hold);
    exp_t e;
    sw_operand = a;
    press(D + $urandom_range(0, 3));
    check("state_after_a", state, 32'd1);
    check("captured_a", operand_a, a);
    check("valid_cleared", valid, 32'd0);
    sw_operand = b;
    mode       = m;
    e          = model(a, b, m);
    sbq.push_back(e);
    press(D + $urandom_range(0, 3));
    check("state_show", state, 32'd3);
    check("scoreboard_drained", sbq.size(), 32'd0);
    sw_operand = W'($urandom);
    mode       = 2'($urandom);
    repeat (5) @(negedge clk);
    check("hold_result", result, e.res);
    check("hold_mag", result_mag, e.mag);
    press(show_hold);
    check("state_back_load_a", state, 32'd0);
    check("valid_held_in_load_a", valid, 32'd1);
    check("operand_a_unchanged", operand_a, a);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_n      = 1'b1;
    sw_operand = '0;
    mode       = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_state", state, 32'd0);
    check("reset_valid", valid, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short glitches never advance, long presses advance exactly once
    for (int i = 1; i < D; i++) begin
      press(i);
      check("glitch_no_advance", state, 32'd0);
    end

    run_tx(4'b1001, 4'b1000, 2'b00, D);
    run_tx(4'b0011, 4'b0101, 2'b01, D);
    run_tx(4'b0111, 4'b0001, 2'b10, D);
    run_tx(4'b1000, 4'b1000, 2'b10, D);
    run_tx(4'b0101, 4'b0101, 2'b01, D);
    run_tx(4'b1010, 4'b1010, 2'b11, D);
    // Key held long across SHOW->LOAD_A must not re-capture A
    run_tx(4'b0110, 4'b1100, 2'b11, 30);
    repeat (10) @(negedge clk);
    check("held_key_no_recapture", state, 32'd0);

    // Asynchronous reset in LOAD_B mid-debounce
    sw_operand = 4'b1011;
    press(D);
    check("state_before_reset", state, 32'd1);
    key_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    key_n = 1'b1;
    #1;
    check("async_reset_state", state, 32'd0);
    check("async_reset_operand_a", operand_a, 32'd0);
    check("async_reset_valid", valid, 32'd0);
    check("async_reset_result", result, 32'd0);
    check("async_reset_mag", result_mag, 32'd0);
    check("async_reset_flags", {carry, overflow, negative}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_press_after_reset", state, 32'd0);

    for (int i = 0; i < 25; i++) begin
      run_tx(W'($urandom), W'($urandom), 2'($urandom), D + $urandom_range(0, 2));
    end

    check("scoreboard_empty_at_end", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
